branch_predictor_bht: RTL and testbench
=======================================

# branch_predictor_bht

Direct-mapped branch history table with 2-bit saturating counters and branch target storage, sitting beside the fetch stage. It produces the per-fetch prediction bundle: counter, valid, prediction and target. The bundle travels down the pipeline stage latches and returns on the update port once the branch resolves. On that return the block updates the table and raises a one-cycle mispredict redirect toward fetch.

## Interface
- ENTRIES, 16: table depth; power of two, 4..256; IDX_W = log2(ENTRIES)
- CNT_INIT, 2'b01: counter value written on allocation (weakly not-taken)
- stg_clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- stg_ena  in  1  stage enable; lookup registers advance only when high
- fetch_pc  in  32  PC being fetched
- pred_counter  out  2  counter of indexed entry (0 on miss)
- pred_valid  out  1  entry valid and tag match
- pred_taken  out  1  pred_valid & pred_counter[1]
- pred_target  out  32  stored target (0 on miss)
- upd_en  in  1  resolved-branch update strobe, one cycle per branch
- upd_pc  in  32  PC of resolved instruction
- upd_flag  in  2  00 not a branch, 01 conditional, 10 unconditional jump, 11 treated as 00
- upd_counter  in  2  counter carried with the instruction
- upd_valid  in  1  pred_valid carried with the instruction
- upd_prediction  in  1  pred_taken carried with the instruction
- upd_pred_target  in  32  pred_target carried with the instruction
- upd_taken  in  1  actual outcome (forced taken internally when upd_flag=10)
- upd_target  in  32  actual target
- mispredict  out  1  registered redirect strobe
- redirect_pc  out  32  correct next PC, meaningful when mispredict=1
- stat_branches  out  16  resolved branches, saturates at 16'hFFFF
- stat_mispredicts  out  16  mispredicts, saturates at 16'hFFFF

## Operation
- Index = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2]. Each entry holds valid, tag, 2-bit counter, 32-bit target.
- Lookup: on a stg_clk edge with stg_ena=1, registers the entry read for fetch_pc into pred_*. On a miss, pred_counter=0, pred_valid=0, pred_taken=0, pred_target=0. With stg_ena=0, pred_* hold.
- Update fires when upd_en=1 and upd_flag is 01 or 10; otherwise it is ignored: no table write, no stats change, mispredict=0.
- Effective outcome T = upd_taken | (upd_flag==10).
- New counter base = upd_valid ? upd_counter : CNT_INIT. Result is base+1 if T, base-1 if not T, saturating at 3 and 0. The carried counter is used; the table is not re-read.
- Write rule: if upd_valid=1 or T=1, write entry {valid=1, tag, new counter, target = T ? upd_target : old stored target}. A not-taken branch with upd_valid=0 is not allocated.
- Mispredict = (upd_prediction != T) | (T & upd_prediction & (upd_pred_target != upd_target)).
- redirect_pc = T ? upd_target : upd_pc+4 (32-bit wrap).
- stat_branches increments on every accepted update. stat_mispredicts increments when mispredict is computed as 1. Both saturate at 16'hFFFF.

## Timing
- Lookup latency: 1 cycle (fetch_pc at edge N -> pred_* valid after edge N).
- Update: table write, stats, mispredict and redirect_pc all register on the same edge that samples upd_en. mispredict is high for exactly one cycle.
- Updates are accepted regardless of stg_ena.
- Same-edge lookup and update to the same index: the lookup returns the newly written values (write-first bypass). Different indices are independent.
- Reset asserted at any time, including mid-update: all entries invalid; pred_* = 0, mispredict = 0, redirect_pc = 0, stats = 0. First valid lookup is on the first edge after reset deasserts.

## Test plan
- Reset, then lookup 0x100 -> pred_valid=0, pred_counter=0, pred_taken=0, pred_target=0; mispredict stays 0.
- Update pc=0x100, flag=01, upd_valid=0, prediction=0, taken=1, target=0x200 -> mispredict=1 for one cycle, redirect_pc=0x200. Next lookup 0x100 -> valid=1, counter=2, taken=1, target=0x200.
- Four taken updates carrying counter 2, then 3, 3, 3 -> stored counter stays 3. Then not-taken with counter=3 -> counter 2, mispredict=1, redirect_pc=0x104.
- Not-taken update, upd_valid=0, pc=0x300 -> no allocation; lookup 0x300 misses; stat_branches+1, stat_mispredicts unchanged.
- Taken jump (flag=10, upd_taken=0) predicted taken with pred_target=0x400, actual 0x480 -> mispredict=1, redirect_pc=0x480, stored target 0x480.
- Same-cycle lookup and update to the same index -> pred_* reflect the new entry. Reset pulse during upd_en -> no write, all outputs 0.

Source files
------------

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht
// Direct-mapped branch history table beside the fetch stage. Each entry keeps
// a valid bit, the upper PC bits as tag, a 2-bit saturating direction counter
// and the last taken target. Lookups are registered once per enabled stage
// cycle. Resolved branches come back on the upd_* port carrying the
// prediction bundle that was issued for them; the table is written and a
// one-cycle redirect is raised on the edge that samples the update.
//
// Handshake: upd_en is a single-cycle strobe with no back-pressure. Every
// cycle with upd_en=1 and a branch flag (01 or 10) is consumed on that edge,
// independent of stg_ena. There is no ready signal.
module branch_predictor_bht #(
  parameter int unsigned ENTRIES  = 16,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic        stg_clk,
  input  logic        reset,
  input  logic        stg_ena,
  input  logic [31:0] fetch_pc,
  output logic [1:0]  pred_counter,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic [1:0]  upd_flag,
  input  logic [1:0]  upd_counter,
  input  logic        upd_valid,
  input  logic        upd_prediction,
  input  logic [31:0] upd_pred_target,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [15:0] stat_branches,
  output logic [15:0] stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  // Table storage
  logic             valid_q [ENTRIES];
  logic             valid_d [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [TAG_W-1:0] tag_d   [ENTRIES];
  logic [1:0]       cnt_q   [ENTRIES];
  logic [1:0]       cnt_d   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [31:0]      tgt_d   [ENTRIES];

  // Registered prediction bundle
  logic [1:0]  pred_counter_q, pred_counter_d;
  logic        pred_valid_q,   pred_valid_d;
  logic        pred_taken_q,   pred_taken_d;
  logic [31:0] pred_target_q,  pred_target_d;

  // Registered update results
  logic        mispredict_q,   mispredict_d;
  logic [31:0] redirect_pc_q,  redirect_pc_d;
  logic [15:0] stat_br_q,      stat_br_d;
  logic [15:0] stat_mis_q,     stat_mis_d;

  // Address decomposition
  logic [IDX_W-1:0] fetch_idx, upd_idx;
  logic [TAG_W-1:0] fetch_tag, upd_tag;
  logic             unused_fetch_low;

  assign fetch_idx        = fetch_pc[IDX_W+1:2];
  assign fetch_tag        = fetch_pc[31:IDX_W+2];
  assign upd_idx          = upd_pc[IDX_W+1:2];
  assign upd_tag          = upd_pc[31:IDX_W+2];
  assign unused_fetch_low = ^fetch_pc[1:0];

  // Update decode
  logic       upd_accept;
  logic       eff_taken;
  logic [1:0] cnt_base;
  logic [1:0] cnt_new;
  logic       upd_write;
  logic       mis_calc;

  // Decode the resolved branch: acceptance, effective outcome, new counter
  always_comb begin
    upd_accept = upd_en && ((upd_flag == 2'b01) || (upd_flag == 2'b10));
    eff_taken  = upd_taken || (upd_flag == 2'b10);
    cnt_base   = upd_valid ? upd_counter : CNT_INIT;
    cnt_new    = cnt_base;
    if (eff_taken) begin
      if (cnt_base != 2'b11) cnt_new = cnt_base + 2'd1;
    end else begin
      if (cnt_base != 2'b00) cnt_new = cnt_base - 2'd1;
    end
    // Not-taken branches without a prior entry are not allocated
    upd_write  = upd_accept && (upd_valid || eff_taken);
    mis_calc   = (upd_prediction != eff_taken) ||
                 (eff_taken && upd_prediction && (upd_pred_target != upd_target));
  end

  // Next table contents: at most one entry changes per cycle
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    if (upd_write) begin
      valid_d[upd_idx] = 1'b1;
      tag_d[upd_idx]   = upd_tag;
      cnt_d[upd_idx]   = cnt_new;
      tgt_d[upd_idx]   = eff_taken ? upd_target : tgt_q[upd_idx];
    end
  end

  // Lookup reads the post-write table so a same-edge update is visible
  always_comb begin
    logic hit;
    hit            = valid_d[fetch_idx] && (tag_d[fetch_idx] == fetch_tag);
    pred_counter_d = pred_counter_q;
    pred_valid_d   = pred_valid_q;
    pred_taken_d   = pred_taken_q;
    pred_target_d  = pred_target_q;
    if (stg_ena) begin
      pred_valid_d   = hit;
      pred_counter_d = hit ? cnt_d[fetch_idx] : 2'b00;
      pred_taken_d   = hit && cnt_d[fetch_idx][1];
      pred_target_d  = hit ? tgt_d[fetch_idx] : 32'h0;
    end
  end

  // Redirect strobe, redirect PC and saturating statistics
  always_comb begin
    mispredict_d  = upd_accept && mis_calc;
    redirect_pc_d = redirect_pc_q;
    stat_br_d     = stat_br_q;
    stat_mis_d    = stat_mis_q;
    if (upd_accept) begin
      redirect_pc_d = eff_taken ? upd_target : (upd_pc + 32'd4);
      if (stat_br_q != 16'hFFFF) stat_br_d = stat_br_q + 16'd1;
      if (mis_calc && (stat_mis_q != 16'hFFFF)) stat_mis_d = stat_mis_q + 16'd1;
    end
  end

  // State registers; reset clears the whole table and all outputs
  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      valid_q        <= '{default: 1'b0};
      tag_q          <= '{default: '0};
      cnt_q          <= '{default: 2'b00};
      tgt_q          <= '{default: 32'h0};
      pred_counter_q <= 2'b00;
      pred_valid_q   <= 1'b0;
      pred_taken_q   <= 1'b0;
      pred_target_q  <= 32'h0;
      mispredict_q   <= 1'b0;
      redirect_pc_q  <= 32'h0;
      stat_br_q      <= 16'h0;
      stat_mis_q     <= 16'h0;
    end else begin
      valid_q        <= valid_d;
      tag_q          <= tag_d;
      cnt_q          <= cnt_d;
      tgt_q          <= tgt_d;
      pred_counter_q <= pred_counter_d;
      pred_valid_q   <= pred_valid_d;
      pred_taken_q   <= pred_taken_d;
      pred_target_q  <= pred_target_d;
      mispredict_q   <= mispredict_d;
      redirect_pc_q  <= redirect_pc_d;
      stat_br_q      <= stat_br_d;
      stat_mis_q     <= stat_mis_d;
    end
  end

  assign pred_counter     = pred_counter_q;
  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign pred_target      = pred_target_q;
  assign mispredict       = mispredict_q;
  assign redirect_pc      = redirect_pc_q;
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: directed scenarios followed by random
// traffic, all compared against a table model kept as plain integer arrays.
module tb_branch_predictor_bht;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        stg_ena;
  logic [31:0] fetch_pc;
  logic [1:0]  pred_counter;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic [1:0]  upd_flag, upd_counter;
  logic        upd_valid, upd_prediction, upd_taken;
  logic [31:0] upd_pred_target, upd_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] stat_branches, stat_mispredicts;

  branch_predictor_bht dut (
    .stg_clk(clk), .reset(reset), .stg_ena(stg_ena), .fetch_pc(fetch_pc),
    .pred_counter(pred_counter), .pred_valid(pred_valid),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_flag(upd_flag),
    .upd_counter(upd_counter), .upd_valid(upd_valid),
    .upd_prediction(upd_prediction), .upd_pred_target(upd_pred_target),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];   // expected redirect PCs

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int          m_cnt   [16];
  logic [31:0] m_tgt   [16];

  int          e_cnt;
  bit          e_valid, e_taken, e_mis;
  logic [31:0] e_target;
  int          e_sbr, e_smis;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_cnt[i] = 0; m_tgt[i] = 0;
    end
    e_cnt = 0; e_valid = 0; e_taken = 0; e_target = 0; e_mis = 0;
    e_sbr = 0; e_smis = 0;
    exp_q.delete();
  endtask

  // Predict what the next edge produces from the currently driven inputs
  task automatic model_step();
    bit br, t, mis;
    int base, nc, ui, fi;
    br  = upd_en && (upd_flag == 2'd1 || upd_flag == 2'd2);
    t   = upd_taken || (upd_flag == 2'd2);
    mis = 0;
    if (br) begin
      base = upd_valid ? int'(upd_counter) : 1;
      nc   = t ? ((base + 1 > 3) ? 3 : base + 1) : ((base - 1 < 0) ? 0 : base - 1);
      mis  = (upd_prediction != t) || (t && upd_prediction && upd_pred_target != upd_target);
      ui   = (upd_pc / 4) % 16;
      if (upd_valid || t) begin
        m_valid[ui] = 1;
        m_tag[ui]   = upd_pc / 64;
        m_cnt[ui]   = nc;
        if (t) m_tgt[ui] = upd_target;
      end
      if (e_sbr < 65535) e_sbr++;
      if (mis && e_smis < 65535) e_smis++;
      if (mis) exp_q.push_back(t ? upd_target : upd_pc + 32'd4);
    end
    e_mis = mis;
    if (stg_ena) begin
      fi = (fetch_pc / 4) % 16;
      if (m_valid[fi] && m_tag[fi] == fetch_pc / 64) begin
        e_valid = 1; e_cnt = m_cnt[fi]; e_taken = (m_cnt[fi] >= 2); e_target = m_tgt[fi];
      end else begin
        e_valid = 0; e_cnt = 0; e_taken = 0; e_target = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("pred_counter", 32'(pred_counter), 32'(e_cnt));
    check_val("pred_valid", 32'(pred_valid), 32'(e_valid));
    check_val("pred_taken", 32'(pred_taken), 32'(e_taken));
    check_val("pred_target", pred_target, e_target);
    check_val("mispredict", 32'(mispredict), 32'(e_mis));
    if (e_mis && exp_q.size() > 0) check_val("redirect_pc", redirect_pc, exp_q.pop_front());
    check_val("stat_branches", 32'(stat_branches), 32'(e_sbr));
    check_val("stat_mispredicts", 32'(stat_mispredicts), 32'(e_smis));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk); #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    upd_en = 0; upd_pc = 0; upd_flag = 0; upd_counter = 0; upd_valid = 0;
    upd_prediction = 0; upd_pred_target = 0; upd_taken = 0; upd_target = 0;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic [1:0] flag,
                           input logic [1:0] cnt, input logic vld, input logic pr,
                           input logic [31:0] ptgt, input logic tk, input logic [31:0] tgt);
    upd_en = 1; upd_pc = pc; upd_flag = flag; upd_counter = cnt; upd_valid = vld;
    upd_prediction = pr; upd_pred_target = ptgt; upd_taken = tk; upd_target = tgt;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_pred"}, {29'b0, pred_counter, pred_valid} | 32'(pred_taken), 32'h0);
    check_val({tag, "_target"}, pred_target, 32'h0);
    check_val({tag, "_mis"}, 32'(mispredict), 32'h0);
    check_val({tag, "_redirect"}, redirect_pc, 32'h0);
    check_val({tag, "_stats"}, {stat_branches, stat_mispredicts}, 32'h0);
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    stg_ena = 1; fetch_pc = 32'h100;
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk); reset = 0;

    // Miss on empty table
    tick();
    // First taken branch allocates; same-edge lookup sees it
    drive_upd(32'h100, 2'b01, 2'd0, 0, 0, 32'h0, 1, 32'h200); tick();
    idle_inputs(); tick();
    // Counter saturates at 3
    drive_upd(32'h100, 2'b01, 2'd2, 1, 1, 32'h200, 1, 32'h200); tick();
    drive_upd(32'h100, 2'b01, 2'd3, 1, 1, 32'h200, 1, 32'h200); tick();
    drive_upd(32'h100, 2'b01, 2'd3, 1, 1, 32'h200, 1, 32'h200); tick();
    drive_upd(32'h100, 2'b01, 2'd3, 1, 1, 32'h200, 1, 32'h200); tick();
    // Not taken from strong: mispredict, redirect to fall-through
    drive_upd(32'h100, 2'b01, 2'd3, 1, 1, 32'h200, 0, 32'h999); tick();
    // Not-taken unallocated branch: no entry, no mispredict
    fetch_pc = 32'h300;
    drive_upd(32'h300, 2'b01, 2'd0, 0, 0, 32'h0, 0, 32'h0); tick();
    idle_inputs(); tick();
    // Jump with wrong predicted target
    fetch_pc = 32'h500;
    drive_upd(32'h500, 2'b10, 2'd2, 1, 1, 32'h400, 0, 32'h480); tick();
    idle_inputs(); tick();
    // Ignored flags
    drive_upd(32'h500, 2'b00, 2'd0, 0, 1, 32'h0, 1, 32'h7); tick();
    drive_upd(32'h500, 2'b11, 2'd0, 0, 1, 32'h0, 1, 32'h7); tick();
    // Stage hold
    idle_inputs(); stg_ena = 0; fetch_pc = 32'h100; tick();
    stg_ena = 1; tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      stg_ena  = ($urandom_range(0, 7) != 0);
      fetch_pc = rand_pc();
      if ($urandom_range(0, 2) != 0) begin
        drive_upd(($urandom_range(0, 3) == 0) ? fetch_pc : rand_pc(),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  32'h1000 + 32'($urandom_range(0, 3)) * 4, 1'($urandom_range(0, 1)),
                  32'h1000 + 32'($urandom_range(0, 3)) * 4);
      end else begin
        idle_inputs();
      end
      tick();
    end

    // Reset pulse while an update is presented
    drive_upd(32'h100, 2'b01, 2'd0, 0, 0, 32'h0, 1, 32'h640);
    fetch_pc = 32'h100;
    reset = 1;
    #1 check_all_zero("async_reset");
    @(posedge clk); #1 check_all_zero("reset_upd");
    @(negedge clk); reset = 0; idle_inputs();
    model_reset();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
